// File: rtl/i2c_arbitration_monitor.sv
// i2c_arbitration_monitor
// Watches a multi-master I2C bus from the point of view of one master.
// The raw SCL/SDA lines are synchronised and de-glitched, START/STOP and
// SCL rising edges are extracted, and while this master transmits, the
// value it drives is compared with the bus to flag lost arbitration.
module i2c_arbitration_monitor #(
    parameter int FILTER_DEPTH   = 3,
    parameter int CNT_WIDTH      = 8,
    parameter bit STRICT_COMPARE = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 scl_in,
    input  logic                 sda_in,
    input  logic                 sda_out,
    input  logic                 master_mode,
    input  logic                 data_transfer_dir,
    input  logic                 ack_transfer_dir,
    input  logic                 clear,
    output logic                 start_detect,
    output logic                 stop_detect,
    output logic                 arbitration_lost,
    output logic                 arbitration_lost_sticky,
    output logic                 bus_error,
    output logic                 bus_busy,
    output logic [3:0]           lost_bit_index,
    output logic [CNT_WIDTH-1:0] lost_count
);

    // Filter run-length counter: must hold FILTER_DEPTH-1 (up to 7).
    localparam int                   FCW       = 4;
    localparam logic [FCW-1:0]       FILT_LAST = FCW'(FILTER_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [3:0]           BIT_LAST  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    logic           scl_meta_r;
    logic           scl_sync_r;
    logic           sda_meta_r;
    logic           sda_sync_r;
    logic           scl_filt_r;
    logic           sda_filt_r;
    logic [FCW-1:0] scl_cnt_r;
    logic [FCW-1:0] sda_cnt_r;
    logic           scl_prev_r;
    logic           sda_prev_r;
    state_t         state_r;
    logic [3:0]     bit_idx_r;

    logic                 scl_rise_s;
    logic                 start_s;
    logic                 stop_s;
    logic                 qualify_s;
    logic                 loss_s;
    logic                 fault_s;
    logic [3:0]           bit_next_s;
    logic [CNT_WIDTH-1:0] cnt_base_s;
    logic [CNT_WIDTH-1:0] cnt_inc_s;

    // Two-flop synchroniser for the asynchronous bus lines; idles high.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
        end
    end

    // Stability filter: a line follows its synchronised value only after
    // FILTER_DEPTH consecutive samples disagreeing with the filtered value.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
            scl_cnt_r  <= {FCW{1'b0}};
            sda_cnt_r  <= {FCW{1'b0}};
        end else begin
            if (scl_sync_r != scl_filt_r) begin
                if (scl_cnt_r == FILT_LAST) begin
                    scl_filt_r <= scl_sync_r;
                    scl_cnt_r  <= {FCW{1'b0}};
                end else begin
                    scl_cnt_r  <= scl_cnt_r + 4'd1;
                end
            end else begin
                scl_cnt_r <= {FCW{1'b0}};
            end
            if (sda_sync_r != sda_filt_r) begin
                if (sda_cnt_r == FILT_LAST) begin
                    sda_filt_r <= sda_sync_r;
                    sda_cnt_r  <= {FCW{1'b0}};
                end else begin
                    sda_cnt_r  <= sda_cnt_r + 4'd1;
                end
            end else begin
                sda_cnt_r <= {FCW{1'b0}};
            end
        end
    end

    // Previous filtered values for edge extraction.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_filt_r;
            sda_prev_r <= sda_filt_r;
        end
    end

    // Bus events, compare result and next counter values.
    always_comb begin
        scl_rise_s = scl_filt_r & ~scl_prev_r;
        // SCL must be high on both samples so a simultaneous SCL/SDA
        // change (e.g. lines settling after reset) is never a condition.
        start_s    = scl_filt_r & scl_prev_r & sda_prev_r & ~sda_filt_r;
        stop_s     = scl_filt_r & scl_prev_r & ~sda_prev_r & sda_filt_r;
        qualify_s  = master_mode & (data_transfer_dir | ack_transfer_dir);
        if (STRICT_COMPARE) begin
            loss_s  = sda_out ^ sda_filt_r;
            fault_s = 1'b0;
        end else begin
            loss_s  = sda_out & ~sda_filt_r;
            fault_s = ~sda_out & sda_filt_r;
        end
        if (bit_idx_r == BIT_LAST) begin
            bit_next_s = 4'd0;
        end else begin
            bit_next_s = bit_idx_r + 4'd1;
        end
        // A loss coinciding with clear counts from zero.
        if (clear) begin
            cnt_base_s = {CNT_WIDTH{1'b0}};
        end else begin
            cnt_base_s = lost_count;
        end
        if (cnt_base_s == CNT_MAX) begin
            cnt_inc_s = cnt_base_s;
        end else begin
            cnt_inc_s = cnt_base_s + CNT_WIDTH'(1'b1);
        end
    end

    // Arbitration FSM with registered event pulses and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r                 <= ST_IDLE;
            bit_idx_r               <= 4'd0;
            start_detect            <= 1'b0;
            stop_detect             <= 1'b0;
            arbitration_lost        <= 1'b0;
            arbitration_lost_sticky <= 1'b0;
            bus_error               <= 1'b0;
            bus_busy                <= 1'b0;
            lost_bit_index          <= 4'd0;
            lost_count              <= {CNT_WIDTH{1'b0}};
        end else begin
            start_detect     <= start_s;
            stop_detect      <= stop_s;
            arbitration_lost <= 1'b0;
            // Clear first so a same-cycle loss or error below overrides it.
            if (clear) begin
                arbitration_lost_sticky <= 1'b0;
                bus_error               <= 1'b0;
                lost_bit_index          <= 4'd0;
                lost_count              <= {CNT_WIDTH{1'b0}};
            end
            if (!enable) begin
                state_r  <= ST_IDLE;
                bus_busy <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_s) begin
                            state_r   <= ST_ACTIVE;
                            bit_idx_r <= 4'd0;
                            bus_busy  <= 1'b1;
                        end else begin
                            bus_busy  <= 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (stop_s) begin
                            if (bit_idx_r != 4'd0) begin
                                bus_error <= 1'b1;
                            end
                            state_r  <= ST_IDLE;
                            bus_busy <= 1'b0;
                        end else if (start_s) begin
                            if (bit_idx_r != 4'd0) begin
                                bus_error <= 1'b1;
                            end
                            bit_idx_r <= 4'd0;
                        end else if (scl_rise_s) begin
                            bit_idx_r <= bit_next_s;
                            if (qualify_s && loss_s) begin
                                state_r                 <= ST_LOST;
                                arbitration_lost        <= 1'b1;
                                arbitration_lost_sticky <= 1'b1;
                                lost_bit_index          <= bit_idx_r;
                                lost_count              <= cnt_inc_s;
                            end else if (qualify_s && fault_s) begin
                                bus_error <= 1'b1;
                            end
                        end
                    end
                    ST_LOST: begin
                        if (stop_s) begin
                            state_r  <= ST_IDLE;
                            bus_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        bus_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/i2c_arbitration_monitor.md
I2C_ARBITRATION_MONITOR -- requirements
Module: i2c_arbitration_monitor

Interface
REQ-001 SHALL have parameter FILTER_DEPTH, default 3: number of consecutive equal synchronised samples (1..8) required before filtered SCL/SDA change.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the arbitration-loss event counter.
REQ-003 SHALL have parameter STRICT_COMPARE, default 0: 1 = any SDA mismatch is a loss; 0 = only driven-1/sampled-0 is a loss.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  monitor enable; 0 holds FSM in IDLE, counters frozen.
REQ-007 SHALL have ports scl_in, sda_in  input  1 each  raw bus lines, asynchronous.
REQ-008 SHALL have port sda_out  input  1  value this master drives (1 = released).
REQ-009 SHALL have ports master_mode, data_transfer_dir, ack_transfer_dir  input  1 each  master is transmitting data / ACK bit.
REQ-010 SHALL have port clear  input  1  one-cycle pulse clearing sticky flags and counter.
REQ-011 SHALL have ports start_detect, stop_detect, arbitration_lost  output  1 each  single-cycle event pulses.
REQ-012 SHALL have ports arbitration_lost_sticky, bus_error, bus_busy  output  1 each  status levels.
REQ-013 SHALL have port lost_bit_index  output  4  bit position (0..8) at last loss.
REQ-014 SHALL have port lost_count  output  CNT_WIDTH  number of losses since reset/clear.

Function
REQ-015 SHALL pass scl_in/sda_in through a 2-flop synchroniser, then a stability filter updating each filtered line only after FILTER_DEPTH identical consecutive samples; raw-to-filtered latency 2+FILTER_DEPTH cycles.
REQ-016 SHALL derive scl_rise (filtered SCL 0->1), START (filtered SDA 1->0 while filtered SCL 1), STOP (filtered SDA 0->1 while filtered SCL 1), each valid for one cycle.
REQ-017 SHALL register start_detect/stop_detect one cycle after the qualifying filtered edge.
REQ-018 SHALL implement FSM IDLE, ACTIVE, LOST; IDLE->ACTIVE on START; ACTIVE->ACTIVE on repeated START (bit counter reset to 0); ACTIVE->LOST on loss; ACTIVE/LOST->IDLE on STOP; LOST ignores further compares; enable=0 forces IDLE next cycle.
REQ-019 SHALL keep bus_busy = 1 in ACTIVE and LOST, 0 in IDLE.
REQ-020 SHALL count scl_rise in ACTIVE as bit index 0..8, wrapping 8->0; counter cleared on START.
REQ-021 SHALL evaluate loss at scl_rise in ACTIVE when master_mode & (data_transfer_dir | ack_transfer_dir): STRICT_COMPARE=0 -> loss iff sda_out=1 & filtered SDA=0; STRICT_COMPARE=1 -> loss iff sda_out != filtered SDA.
REQ-022 SHALL, on loss, pulse arbitration_lost for one cycle the cycle after scl_rise, set arbitration_lost_sticky, capture bit index into lost_bit_index, increment lost_count, saturating at 2^CNT_WIDTH-1.
REQ-023 SHALL, with STRICT_COMPARE=0, set bus_error when sda_out=0 & filtered SDA=1 at a qualifying scl_rise (line fault), with no state change.
REQ-024 SHALL set bus_error on START or STOP in ACTIVE while bit index is 1..8 (misplaced condition); FSM still follows REQ-018.
REQ-025 SHALL, on clear, zero arbitration_lost_sticky, bus_error, lost_count, lost_bit_index next cycle; a loss in the same cycle as clear wins (sticky=1, count=1).
REQ-026 SHALL not evaluate loss when master_mode=0, both direction inputs 0, or state IDLE.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set FSM IDLE, synchroniser/filter flops to 1 (bus idle), all outputs 0, lost_count 0, lost_bit_index 0.
REQ-028 SHALL give reset priority over clear, enable and all bus events, including mid-frame; first START after reset is required before any loss evaluation.

Verification
REQ-029 SHALL test: START, master sends 0xA5 with sda_out matching bus -> no arbitration_lost, lost_count=0, bus_busy=1 until STOP.
REQ-030 SHALL test: master drives 1 at bit 3, bus forced 0 -> arbitration_lost one pulse, lost_bit_index=3, lost_count=1, state LOST until STOP, then bus_busy=0.
REQ-031 SHALL test: SDA glitch of FILTER_DEPTH-1 cycles while SCL high -> no start_detect/stop_detect; glitch of FILTER_DEPTH+1 cycles -> detected.
REQ-032 SHALL test: STRICT_COMPARE=0, sda_out=0, bus 1 -> bus_error=1, arbitration_lost=0; STRICT_COMPARE=1 same stimulus -> arbitration_lost=1.
REQ-033 SHALL test: CNT_WIDTH=2, five losses -> lost_count=3; clear coincident with sixth loss -> lost_count=1, sticky=1.
REQ-034 SHALL test: reset asserted at bit 5 of a frame -> all outputs 0 next cycle, no loss evaluated until new START.
